// File: rtl/sha_msg_sequencer_if.sv
// sha_msg_sequencer_if: big-endian 32-bit message word stream into the SHA-256 sequencer.
interface sha_msg_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [2:0]  s_bytes;
  modport master (output s_valid, s_data, s_last, s_bytes, input s_ready);
  modport slave  (input s_valid, s_data, s_last, s_bytes, output s_ready);
endinterface

// File: rtl/sha_msg_sequencer.sv
// sha_msg_sequencer: pads a word-streamed message into 512-bit blocks and drives a SHA-256 core's
// init/next handshake, returning the final digest.
module sha_msg_sequencer #(
  parameter int LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sha_msg_sequencer_if.slave   s,
  output logic [511:0]         core_block_o,
  output logic                 core_init_o,
  output logic                 core_next_o,
  input  logic                 core_ready_i,
  input  logic [255:0]         core_digest_i,
  input  logic                 core_digest_valid_i,
  output logic [255:0]         digest_o,
  output logic                 digest_valid_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [16];
  logic [31:0] mem_d [16];
  logic [4:0] widx_q, widx_d;
  logic [LEN_W-1:0] bc_q, bc_d, bc_add;
  logic first_q, first_d, fin_q, fin_d, extra_q, extra_d, pad_q, pad_d;
  logic busy_q, busy_d, init_q, init_d, nxt_q, nxt_d, dv_q, dv_d, rdy_q;
  logic [1:0] skip_q, skip_d;
  logic [511:0] blk_q, blk_d, flat;
  logic [255:0] dig_q, dig_d;
  logic [2:0] sb;
  logic [6:0] nb;
  logic [63:0] len;
  logic xfer;
  assign xfer   = s.s_valid && rdy_q;
  assign sb     = s.s_bytes > 3'd4 ? 3'd4 : s.s_bytes;
  assign nb     = {widx_q, 2'b00} + 7'(sb);
  assign bc_add = bc_q + LEN_W'(sb);
  assign len    = 64'(state_q == FILL ? bc_add : bc_q) << 3;
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    widx_d  = widx_q;
    bc_d    = bc_q;
    first_d = first_q;
    fin_d   = fin_q;
    extra_d = extra_q;
    pad_d   = pad_q;
    busy_d  = busy_q;
    init_d  = 1'b0;
    nxt_d   = 1'b0;
    dv_d    = 1'b0;
    skip_d  = skip_q == 2'd0 ? 2'd0 : skip_q - 2'd1;
    blk_d   = blk_q;
    dig_d   = dig_q;
    flat    = '0;
    for (int i = 0; i < 16; i++) flat[511-32*i -: 32] = mem_q[i];
    unique case (state_q)
      FILL: if (xfer) begin
        busy_d = 1'b1;
        if (!s.s_last) begin
          mem_d[widx_q[3:0]] = s.s_data;
          widx_d = widx_q + 5'd1;
          bc_d = bc_q + LEN_W'(4);
          if (widx_q == 5'd15) begin
            state_d = SEND;
            fin_d = 1'b0;
            extra_d = 1'b0;
          end
        end else begin
          bc_d = bc_add;
          // keep the valid bytes and place the 0x80 terminator right after them
          mem_d[widx_q[3:0]] = (s.s_data & ~(32'hffff_ffff >> {sb, 3'b000})) | (32'h8000_0000 >> {sb, 3'b000});
          if (sb == 3'd4 && widx_q != 5'd15) mem_d[widx_q[3:0] + 4'd1] = 32'h8000_0000;
          fin_d = nb <= 7'd55;
          extra_d = nb > 7'd55;
          pad_d = nb == 7'd64;
          if (nb <= 7'd55) begin
            mem_d[14] = len[63:32];
            mem_d[15] = len[31:0];
          end
          state_d = SEND;
        end
      end
      SEND: if (core_ready_i) begin
        blk_d = flat;
        init_d = first_q;
        nxt_d = !first_q;
        first_d = 1'b0;
        skip_d = 2'd2;
        state_d = WAIT;
      end
      // the stale digest_valid from the previous block is masked while skip_q drains
      WAIT: if (skip_q == 2'd0 && core_digest_valid_i) begin
        mem_d = '{default: '0};
        if (fin_q) begin
          dig_d = core_digest_i;
          dv_d = 1'b1;
          busy_d = 1'b0;
          first_d = 1'b1;
          bc_d = '0;
          widx_d = '0;
          fin_d = 1'b0;
          state_d = FILL;
        end else if (extra_q) begin
          mem_d[0] = pad_q ? 32'h8000_0000 : 32'h0;
          mem_d[14] = len[63:32];
          mem_d[15] = len[31:0];
          fin_d = 1'b1;
          extra_d = 1'b0;
          state_d = SEND;
        end else begin
          widx_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      mem_q   <= '{default: '0};
      widx_q  <= '0;
      bc_q    <= '0;
      first_q <= 1'b1;
      fin_q   <= 1'b0;
      extra_q <= 1'b0;
      pad_q   <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      nxt_q   <= 1'b0;
      dv_q    <= 1'b0;
      rdy_q   <= 1'b0;
      skip_q  <= '0;
      blk_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      widx_q  <= widx_d;
      bc_q    <= bc_d;
      first_q <= first_d;
      fin_q   <= fin_d;
      extra_q <= extra_d;
      pad_q   <= pad_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
      nxt_q   <= nxt_d;
      dv_q    <= dv_d;
      rdy_q   <= state_d == FILL;
      skip_q  <= skip_d;
      blk_q   <= blk_d;
      dig_q   <= dig_d;
    end
  end
  assign s.s_ready      = rdy_q;
  assign core_block_o   = blk_q;
  assign core_init_o    = init_q;
  assign core_next_o    = nxt_q;
  assign digest_o       = dig_q;
  assign digest_valid_o = dv_q;
  assign busy_o         = busy_q;
endmodule

// File: tb/tb_sha_msg_sequencer.sv
// tb_sha_msg_sequencer: directed vectors against a behavioural SHA-256 core and known digests.
module tb_sha_msg_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [511:0] core_block;
  logic core_init, core_next, digest_valid, busy;
  logic core_ready = 1'b1;
  logic core_digest_valid = 1'b0;
  logic [255:0] core_digest = '0;
  logic [255:0] digest;
  sha_msg_sequencer_if s();
  sha_msg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s(s),
    .core_block_o(core_block), .core_init_o(core_init), .core_next_o(core_next),
    .core_ready_i(core_ready), .core_digest_i(core_digest), .core_digest_valid_i(core_digest_valid),
    .digest_o(digest), .digest_valid_o(digest_valid), .busy_o(busy)
  );
  always #5 clk = ~clk;
  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0, cnt = 0, n_init = 0, n_next = 0, n_dv = 0, viol = 0, cdv_cyc = 0, dv_cyc = 0;
  logic cdv_prev = 1'b0;
  logic [255:0] h_st = '0;
  logic [511:0] blks[$];
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w[64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction
  function automatic logic [255:0] sha_ref(input logic [7:0] m[$]);
    logic [7:0] p[$];
    logic [63:0] bl;
    logic [511:0] blk;
    logic [255:0] h;
    p = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = H0;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*k+j];
      h = compress(h, blk);
    end
    return h;
  endfunction
  // behavioural core: drops ready/valid on a strobe, answers a few cycles later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_init || core_next) begin
      core_digest_valid <= 1'b0;
      core_ready <= 1'b0;
      h_st <= compress(core_init ? H0 : h_st, core_block);
      cnt <= 3;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_ready <= 1'b1;
        core_digest_valid <= 1'b1;
        core_digest <= h_st;
      end
    end
  end
  always @(negedge clk) begin
    if (core_init) n_init <= n_init + 1;
    if (core_next) n_next <= n_next + 1;
    if (core_init || core_next) blks.push_back(core_block);
    if (core_digest_valid && !cdv_prev) cdv_cyc <= cyc;
    cdv_prev <= core_digest_valid;
    if (digest_valid) begin
      n_dv <= n_dv + 1;
      dv_cyc <= cyc;
    end
    if (s.s_ready && (cnt > 0 || core_init || core_next)) viol <= viol + 1;
  end
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [31:0] d, input logic l, input logic [2:0] b);
    int t = 0;
    s.s_valid = 1'b1;
    s.s_data = d;
    s.s_last = l;
    s.s_bytes = b;
    while (!s.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("s_ready timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask
  task automatic wait_dv(input int base);
    int t = 0;
    while (n_dv <= base && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("digest_valid timeout", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask
  task automatic run_msg(input logic [7:0] m[$]);
    int nw, base;
    logic [31:0] w;
    base = n_dv;
    nw = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = 32'heeeeeeee;
      for (int j = 0; j < 4; j++) if (4*i + j < m.size()) w[31-8*j -: 8] = m[4*i+j];
      put(w, i == nw - 1, (i == nw - 1) ? 3'(m.size() - 4*i) : 3'd4);
    end
    s.s_valid = 1'b0;
    s.s_last = 1'b0;
    wait_dv(base);
    check("digest_valid pulses", 32'(n_dv - base), 32'd1);
  endtask
  initial begin
    logic [7:0] m[$];
    string str;
    int bi, ni, nn, bd, t;
    s.s_valid = 1'b0;
    s.s_data = '0;
    s.s_last = 1'b0;
    s.s_bytes = '0;
    @(negedge clk);
    check("rst s_ready", s.s_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst core_block", core_block, '0);
    check("rst digest", digest, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready after release", s.s_ready, 1'b1);
    // "abc"
    m = '{8'h61, 8'h62, 8'h63};
    bi = blks.size(); ni = n_init; nn = n_next;
    run_msg(m);
    check("abc block", blks[bi], {32'h61626380, 416'h0, 64'h18});
    check("abc init", 32'(n_init - ni), 32'd1);
    check("abc next", 32'(n_next - nn), 32'd0);
    check("abc digest", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    check("abc busy done", busy, 1'b0);
    // empty message
    m = {};
    bi = blks.size();
    run_msg(m);
    check("empty block", blks[bi], {32'h80000000, 480'h0});
    check("empty digest", digest, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    // 56 bytes: terminator fits in block one, length spills to a second block
    str = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m = {};
    for (int i = 0; i < str.len(); i++) m.push_back(8'(str[i]));
    bi = blks.size(); ni = n_init; nn = n_next;
    run_msg(m);
    check("56B nblocks", 32'(blks.size() - bi), 32'd2);
    check("56B block0 tail", blks[bi][63:0], 64'h80000000_00000000);
    check("56B block1", blks[bi+1], {448'h0, 64'h1c0});
    check("56B init", 32'(n_init - ni), 32'd1);
    check("56B next", 32'(n_next - nn), 32'd1);
    check("56B digest", digest, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
    // 64 x 'a': terminator starts the second block
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'h61);
    bi = blks.size();
    run_msg(m);
    check("64B nblocks", 32'(blks.size() - bi), 32'd2);
    check("64B block1", blks[bi+1], {32'h80000000, 416'h0, 64'h200});
    check("64B dv latency", 32'(dv_cyc - cdv_cyc), 32'd1);
    check("64B digest", digest, {256'(sha_ref(m))});
    // 70 bytes with s_valid held high through SEND/WAIT
    m = {};
    for (int i = 0; i < 70; i++) m.push_back(8'(i * 7 + 3));
    bi = blks.size(); ni = n_init; nn = n_next;
    run_msg(m);
    check("70B nblocks", 32'(blks.size() - bi), 32'd2);
    check("70B init", 32'(n_init - ni), 32'd1);
    check("70B next", 32'(n_next - nn), 32'd1);
    check("70B digest", digest, {256'(sha_ref(m))});
    check("s_ready held off", 32'(viol), 32'd0);
    // s_bytes above 4 counts as 4
    bd = n_dv;
    put(32'h61626364, 1'b0, 3'd4);
    put(32'h65666768, 1'b1, 3'd7);
    s.s_valid = 1'b0;
    s.s_last = 1'b0;
    wait_dv(bd);
    m = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    check("s_bytes clamp digest", digest, {256'(sha_ref(m))});
    // reset while the first block of a longer message is in flight
    ni = n_init;
    for (int i = 0; i < 16; i++) put(32'h01020304 + 32'(i), 1'b0, 3'd4);
    s.s_valid = 1'b0;
    t = 0;
    while (n_init == ni && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid-wait strobe seen", 32'(n_init - ni), 32'd1);
    @(negedge clk);
    check("mid-wait busy", busy, 1'b1);
    check("mid-wait s_ready", s.s_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort s_ready", s.s_ready, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort strobes", {core_init, core_next, digest_valid}, 3'b000);
    check("abort core_block", core_block, '0);
    check("abort digest", digest, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ni = n_init; nn = n_next; bd = n_dv;
    repeat (20) @(negedge clk);
    check("no strobe after abort", 32'(n_init - ni + n_next - nn), 32'd0);
    check("no digest_valid after abort", 32'(n_dv - bd), 32'd0);
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m);
    check("post-abort init", 32'(n_init - ni), 32'd1);
    check("post-abort next", 32'(n_next - nn), 32'd0);
    check("post-abort digest", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
